// File: rtl/johnson_phase_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : johnson_phase_decoder
// Decodes a sampled Johnson counter bus into phase index and one-hot form and
// supervises sequence legality, lock, revolutions and errors.
// Rev    : 1.0
// =============================================================================
module johnson_phase_decoder #(
  parameter int N        = 4,
  parameter int PW       = 3,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     q_in,
  output logic [PW-1:0]    phase,
  output logic [2*N-1:0]   phase_oh,
  output logic             valid,
  output logic             locked,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int                c_np     = 2 * N;
  localparam logic [PW-1:0]     c_last   = PW'(c_np - 1);
  localparam logic [c_np-1:0]   c_oh_one = {{(c_np-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_s;
  logic [PW-1:0]    r_prev;
  logic [3:0]       r_run, w_run_nxt;
  logic [PW-1:0]    r_phase;
  logic [c_np-1:0]  r_phase_oh;
  logic             r_valid, r_err, r_tick;
  logic [REV_W-1:0] r_rev_cnt;
  logic [7:0]       r_err_cnt;

  logic [N-1:0]     w_s_inv;
  logic             w_legal, w_step, w_hold, w_bad;
  logic [PW-1:0]    w_phase, w_succ;
  logic             w_err_nxt, w_tick_nxt;

  function automatic logic [PW-1:0] f_popcount(input logic [N-1:0] v);
    logic [PW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + PW'(v[i]);
    return cnt;
  endfunction

  // Legal codes are a run of ones (or zeros) anchored at the LSB: adding one
  // to such a word clears every set bit of it.
  assign w_s_inv = ~r_s;
  assign w_legal = ((r_s & (r_s + N'(1))) == '0) ||
                   ((w_s_inv & (w_s_inv + N'(1))) == '0);
  assign w_phase = !w_legal ? '0 :
                   r_s[N-1] ? PW'(N) + f_popcount(w_s_inv) : f_popcount(r_s);

  assign w_succ = (r_prev == c_last) ? '0 : r_prev + PW'(1);
  assign w_step = w_legal && (w_phase == w_succ);
  assign w_hold = w_legal && (w_phase == r_prev);
  assign w_bad  = !(w_step || w_hold);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_err_nxt   = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_legal) begin
          w_state_nxt = ST_TRACK;
          w_run_nxt   = '0;
        end
      end
      ST_TRACK: begin
        if (w_bad) begin
          w_state_nxt = ST_HUNT;
          w_run_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else if (w_step) begin
          w_run_nxt = r_run + 4'd1;
          if ((r_run + 4'd1) == 4'(LOCK_CNT)) w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_bad) begin
          w_state_nxt = ST_HUNT;
          w_run_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else if (w_step && (r_prev == c_last)) begin
          w_tick_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state    <= ST_HUNT;
      r_s        <= '0;
      r_prev     <= '0;
      r_run      <= '0;
      r_phase    <= '0;
      r_phase_oh <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_tick     <= 1'b0;
      r_rev_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= q_in;
      r_run      <= w_run_nxt;
      if (w_legal) r_prev <= w_phase;
      r_phase    <= w_phase;
      r_phase_oh <= w_legal ? (c_oh_one << w_phase) : '0;
      r_valid    <= w_legal;
      r_err      <= w_err_nxt;
      r_tick     <= w_tick_nxt;
      if (w_tick_nxt) r_rev_cnt <= r_rev_cnt + REV_W'(1);
      if (w_err_nxt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign phase    = r_phase;
  assign phase_oh = r_phase_oh;
  assign valid    = r_valid;
  assign locked   = (r_state == ST_LOCKED);
  assign rev_tick = r_tick;
  assign rev_cnt  = r_rev_cnt;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : tb_johnson_phase_decoder
// Scoreboard bench: a code-table reference model queues expectations that a
// separate monitor compares against the decoder outputs every cycle.
// Rev    : 1.0
// =============================================================================
module tb_johnson_phase_decoder;

  localparam int N        = 4;
  localparam int NP       = 2 * N;
  localparam int PW       = 3;
  localparam int LOCK_CNT = 2;
  localparam int REV_W    = 8;

  localparam int M_HUNT   = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;

  logic             clk = 1'b0;
  logic             clr;
  logic [N-1:0]     q_in;
  logic [PW-1:0]    phase;
  logic [NP-1:0]    phase_oh;
  logic             valid, locked, rev_tick, err;
  logic [REV_W-1:0] rev_cnt;
  logic [7:0]       err_cnt;

  johnson_phase_decoder #(.N(N), .PW(PW), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W)) dut (
    .clk(clk), .clr(clr), .q_in(q_in), .phase(phase), .phase_oh(phase_oh),
    .valid(valid), .locked(locked), .rev_tick(rev_tick), .rev_cnt(rev_cnt),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int valid, phase, oh, locked, tick, err, rev, errc;
    bit chk_phase;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_ticks = 0;

  int m_s, m_prev, m_run, m_st, m_rev, m_errc;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Legal code for phase i: i ones from the LSB, then the ones recede upward.
  function automatic int code_of(input int i);
    if (i < N) return (1 << i) - 1;
    return ((1 << N) - 1) & ~((1 << (i - N)) - 1);
  endfunction

  function automatic int lookup(input int v);
    for (int i = 0; i < NP; i++) if (code_of(i) == v) return i;
    return -1;
  endfunction

  task automatic model_edge(input bit c, input int q);
    exp_t e;
    int   ph;
    bit   lg, stp, hld;
    e = '{default: 0};
    if (!c) begin
      m_s = 0; m_prev = 0; m_run = 0; m_st = M_HUNT; m_rev = 0; m_errc = 0;
      e.chk_phase = 1'b1;
    end else begin
      ph  = lookup(m_s);
      lg  = (ph >= 0);
      stp = lg && (ph == (m_prev + 1) % NP);
      hld = lg && (ph == m_prev);
      if (m_st == M_HUNT) begin
        if (lg) begin m_st = M_TRACK; m_run = 0; end
      end else if (!stp && !hld) begin
        e.err = 1; m_st = M_HUNT; m_run = 0;
      end else if (m_st == M_TRACK) begin
        if (stp) begin
          m_run++;
          if (m_run >= LOCK_CNT) m_st = M_LOCKED;
        end
      end else if (stp && ph == 0) begin
        e.tick = 1;
        m_rev  = (m_rev + 1) % (1 << REV_W);
      end
      if (lg) m_prev = ph;
      if (e.err == 1 && m_errc < 255) m_errc++;
      e.valid     = lg;
      e.chk_phase = lg;
      e.phase     = lg ? ph : 0;
      e.oh        = lg ? (1 << ph) : 0;
      m_s = q;
    end
    e.locked = (m_st == M_LOCKED);
    e.rev    = m_rev;
    e.errc   = m_errc;
    sb.push_back(e);
  endtask

  task automatic drive(input bit c, input int q);
    @(negedge clk);
    clr  = c;
    q_in = N'(q);
    model_edge(c, q);
  endtask

  task automatic drain(input int q);
    drive(1'b1, q);
    drive(1'b1, q);
    @(posedge clk);
    #2;
  endtask

  function automatic int rand_illegal();
    int v;
    do v = $urandom_range(0, (1 << N) - 1); while (lookup(v) >= 0);
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid", int'(valid), e.valid);
        if (e.chk_phase) check("phase", int'(phase), e.phase);
        check("phase_oh", int'(phase_oh), e.oh);
        check("locked", int'(locked), e.locked);
        check("rev_tick", int'(rev_tick), e.tick);
        check("err", int'(err), e.err);
        check("rev_cnt", int'(rev_cnt), e.rev);
        check("err_cnt", int'(err_cnt), e.errc);
        if (rev_tick) mon_ticks++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cur, r;
    clr  = 1'b0;
    q_in = '0;
    m_s = 0; m_prev = 0; m_run = 0; m_st = M_HUNT; m_rev = 0; m_errc = 0;

    for (int i = 0; i < 3; i++) drive(1'b0, $urandom_range(0, 15));

    // Lock, finish the first revolution, then three more full revolutions
    for (int i = 0; i < NP; i++) drive(1'b1, code_of(i));
    for (int rv = 0; rv < 3; rv++)
      for (int i = 0; i < NP; i++) drive(1'b1, code_of(i));
    drain(code_of(NP - 1));
    check("rev_ticks_seen", mon_ticks, 3);
    check("rev_cnt_after_3", int'(rev_cnt), 3);

    // Illegal code while locked, then relock
    drive(1'b1, 4'b0101);
    drive(1'b1, 4'b0001);
    drive(1'b1, 4'b0011);
    drive(1'b1, 4'b0111);
    for (int i = 4; i < NP; i++) drive(1'b1, code_of(i));
    for (int i = 0; i < 3; i++) drive(1'b1, code_of(i));
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0011);
    drain(4'b0011);
    check("locked_through_hold", int'(locked), 1);
    drive(1'b1, 4'b1111);
    drain(4'b1111);
    check("locked_after_skip", int'(locked), 0);

    // Long locked run to wrap the revolution counter
    for (int rv = 0; rv < 257; rv++)
      for (int i = 0; i < NP; i++) drive(1'b1, code_of(i));

    // Repeated skips drive the error counter into saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b0000);
      drive(1'b1, 4'b0011);
    end
    drain(4'b0011);
    check("err_cnt_saturated", int'(err_cnt), 255);

    // Randomized walk with holds, skips, illegal codes and occasional resets
    cur = 0;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(1'b0, $urandom_range(0, 15));
      end else if (r < 70) begin
        cur = (cur + 1) % NP;
        drive(1'b1, code_of(cur));
      end else if (r < 85) begin
        drive(1'b1, code_of(cur));
      end else if (r < 92) begin
        cur = $urandom_range(0, NP - 1);
        drive(1'b1, code_of(cur));
      end else begin
        drive(1'b1, rand_illegal());
      end
    end

    // Reset lands on the edge that would report a revolution tick
    drive(1'b0, 0);
    for (int i = 0; i < NP; i++) drive(1'b1, code_of(i));
    drive(1'b1, code_of(0));
    drive(1'b0, code_of(1));
    for (int i = 1; i < 4; i++) drive(1'b1, code_of(i));
    drain(code_of(3));

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
